// File: rtl/accumulator_drain_controller.sv
// Drains finished accumulator rows into the unified buffer, one row per cycle,
// with write/clear strobes delayed to line up with accumulator read data.
module accumulator_drain_controller #(
  parameter int unsigned MUL_SIZE   = 32,
  parameter int unsigned ACC_ADDR_W = 10,
  parameter int unsigned UB_ADDR_W  = 12,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [8:0]            HEIGHT,
  input  logic [8:0]            WIDTH,
  input  logic [UB_ADDR_W-1:0]  ub_base_addr_i,
  input  logic                  ub_stall_i,
  output logic                  acc_rd_en_o,
  output logic [ACC_ADDR_W-1:0] acc_rd_addr_o,
  output logic                  ub_wr_en_o,
  output logic [UB_ADDR_W-1:0]  ub_wr_addr_o,
  output logic                  acc_clr_o,
  output logic [ACC_ADDR_W-1:0] acc_clr_addr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o
);

  localparam int unsigned CNT_W   = 14;
  localparam int unsigned TILE_SH = $clog2(MUL_SIZE);
  localparam logic [CNT_W-1:0] ACC_DEPTH = CNT_W'(1) << ACC_ADDR_W;
  // All stages except the last; the last one is leaving the pipe this cycle.
  localparam logic [RD_LATENCY-1:0] EARLY_MASK = {RD_LATENCY{1'b1}} >> 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       n_q;
  logic [UB_ADDR_W-1:0]   base_q;
  logic                   clamp_q;

  logic [CNT_W-1:0]       h_tiles, w_tiles, n_raw, n_req;
  logic                   clamp_req;
  logic                   accept;
  logic                   issue;
  logic [ACC_ADDR_W-1:0]  issue_addr;
  logic                   inflight;

  logic [RD_LATENCY-1:0]  vld_q;
  logic [ACC_ADDR_W-1:0]  pidx_q [RD_LATENCY];

  assign h_tiles   = CNT_W'(HEIGHT >> TILE_SH);
  assign w_tiles   = CNT_W'(WIDTH >> TILE_SH);
  assign n_raw     = (h_tiles * w_tiles) << TILE_SH;
  assign clamp_req = (n_raw > ACC_DEPTH);
  assign n_req     = clamp_req ? ACC_DEPTH : n_raw;

  assign inflight  = |(vld_q & EARLY_MASK);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    issue      = 1'b0;
    accept     = 1'b0;
    issue_addr = ACC_ADDR_W'(idx_q);
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          accept     = 1'b1;
          idx_d      = '0;
          issue_addr = '0;
          if (n_req == '0) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            // Row 0 is issued on the accepting edge itself.
            if (!ub_stall_i) begin
              issue = 1'b1;
              idx_d = CNT_W'(1);
              if (n_req == CNT_W'(1)) state_d = DRAIN;
            end
          end
        end
      end
      ISSUE: begin
        if (!ub_stall_i) begin
          issue = 1'b1;
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == n_q - CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      n_q            <= '0;
      base_q         <= '0;
      clamp_q        <= 1'b0;
      vld_q          <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pidx_q[i] <= '0;
      ub_wr_en_o     <= 1'b0;
      ub_wr_addr_o   <= '0;
      acc_clr_addr_o <= '0;
      done_o         <= 1'b0;
      cfg_err_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        n_q     <= n_req;
        base_q  <= ub_base_addr_i;
        clamp_q <= clamp_req;
      end
      vld_q[0] <= issue;
      if (issue) pidx_q[0] <= issue_addr;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) pidx_q[i] <= pidx_q[i-1];
      end
      ub_wr_en_o <= vld_q[RD_LATENCY-1];
      if (vld_q[RD_LATENCY-1]) begin
        ub_wr_addr_o   <= base_q + UB_ADDR_W'(pidx_q[RD_LATENCY-1]);
        acc_clr_addr_o <= pidx_q[RD_LATENCY-1];
      end
      done_o    <= (state_q == DONE);
      cfg_err_o <= (state_q == DONE) && clamp_q;
    end
  end

  assign acc_rd_en_o   = vld_q[0];
  assign acc_rd_addr_o = pidx_q[0];
  assign acc_clr_o     = ub_wr_en_o;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_accumulator_drain_controller.sv
// Randomised bench for accumulator_drain_controller against an event-schedule
// reference model derived from the read/write/done timing rules.
module tb_accumulator_drain_controller;

  localparam int unsigned LAT = 2;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, ub_stall_i;
  logic [8:0]  HEIGHT, WIDTH;
  logic [11:0] ub_base_addr_i;
  logic        acc_rd_en_o, ub_wr_en_o, acc_clr_o, busy_o, done_o, cfg_err_o;
  logic [9:0]  acc_rd_addr_o, acc_clr_addr_o;
  logic [11:0] ub_wr_addr_o;

  always #5 clk_i = ~clk_i;

  accumulator_drain_controller #(
    .MUL_SIZE  (32),
    .ACC_ADDR_W(10),
    .UB_ADDR_W (12),
    .RD_LATENCY(LAT)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .HEIGHT        (HEIGHT),
    .WIDTH         (WIDTH),
    .ub_base_addr_i(ub_base_addr_i),
    .ub_stall_i    (ub_stall_i),
    .acc_rd_en_o   (acc_rd_en_o),
    .acc_rd_addr_o (acc_rd_addr_o),
    .ub_wr_en_o    (ub_wr_en_o),
    .ub_wr_addr_o  (ub_wr_addr_o),
    .acc_clr_o     (acc_clr_o),
    .acc_clr_addr_o(acc_clr_addr_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .cfg_err_o     (cfg_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int edge_no  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  // Reference model: a job is a list of scheduled read, write and done events.
  typedef enum {M_IDLE, M_RUN, M_FIN} mmode_t;
  typedef struct { int at; int idx; } wr_ev_t;

  mmode_t m_mode = M_IDLE;
  int     m_n, m_next, m_base, m_done_edge;
  bit     m_clamp;
  wr_ev_t wr_q[$];

  logic       e_rd, e_wr, e_done, e_err, e_busy;
  int         e_rda, e_wra, e_clra;

  int obs_reads, obs_done_edge, obs_dones, obs_errs, launch_edge;

  task automatic model_edge();
    int n;
    if (rst_i) begin
      m_mode = M_IDLE;
      wr_q.delete();
      e_rd = 0; e_wr = 0; e_done = 0; e_err = 0;
      e_rda = 0; e_wra = 0; e_clra = 0;
    end else begin
      e_rd = 0; e_done = 0; e_err = 0; e_wr = 0;
      if (m_mode == M_IDLE && start_i) begin
        n = (int'(HEIGHT) / 32) * (int'(WIDTH) / 32) * 32;
        m_clamp = (n > 1024);
        m_n = m_clamp ? 1024 : n;
        m_next = 0;
        m_base = int'(ub_base_addr_i);
        if (m_n == 0) begin
          m_mode = M_FIN;
          m_done_edge = edge_no + 1;
        end else begin
          m_mode = M_RUN;
        end
      end
      if (m_mode == M_RUN && !ub_stall_i) begin
        e_rd = 1;
        e_rda = m_next;
        wr_q.push_back('{edge_no + LAT, m_next});
        m_next++;
        if (m_next == m_n) begin
          m_mode = M_FIN;
          m_done_edge = edge_no + LAT + 1;
        end
      end else if (m_mode == M_FIN && edge_no == m_done_edge) begin
        e_done = 1;
        e_err = m_clamp;
        m_mode = M_IDLE;
      end
      if (wr_q.size() > 0 && wr_q[0].at == edge_no) begin
        e_wr = 1;
        e_wra = (m_base + wr_q[0].idx) % 4096;
        e_clra = wr_q[0].idx;
        void'(wr_q.pop_front());
      end
    end
    e_busy = (m_mode != M_IDLE);
  endtask

  task automatic step();
    @(posedge clk_i);
    edge_no++;
    model_edge();
    #1;
    chk("acc_rd_en", 32'(acc_rd_en_o), 32'(e_rd));
    chk("acc_rd_addr", 32'(acc_rd_addr_o), e_rda);
    chk("ub_wr_en", 32'(ub_wr_en_o), 32'(e_wr));
    chk("ub_wr_addr", 32'(ub_wr_addr_o), e_wra);
    chk("acc_clr", 32'(acc_clr_o), 32'(e_wr));
    chk("acc_clr_addr", 32'(acc_clr_addr_o), e_clra);
    chk("busy", 32'(busy_o), 32'(e_busy));
    chk("done", 32'(done_o), 32'(e_done));
    chk("cfg_err", 32'(cfg_err_o), 32'(e_err));
    if (acc_rd_en_o) obs_reads++;
    if (done_o) begin
      obs_dones++;
      obs_done_edge = edge_no;
    end
    if (cfg_err_o) obs_errs++;
    start_i = 1'b0;
  endtask

  task automatic launch(input int h, input int w, input int base);
    HEIGHT = 9'(h);
    WIDTH = 9'(w);
    ub_base_addr_i = 12'(base);
    start_i = 1'b1;
    obs_reads = 0;
    obs_dones = 0;
    obs_errs = 0;
    obs_done_edge = -1;
    launch_edge = edge_no + 1;
    step();
  endtask

  task automatic run_idle(input int max_cycles, input bit rnd);
    for (int i = 0; i < max_cycles && m_mode != M_IDLE; i++) begin
      if (rnd) begin
        ub_stall_i = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 15) == 0) begin
          start_i = 1'b1;
          HEIGHT = 9'($urandom_range(0, 511));
          WIDTH = 9'($urandom_range(0, 511));
        end
      end
      step();
    end
    chk("run_timeout", 32'(m_mode == M_IDLE), 1);
    ub_stall_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; ub_stall_i = 1'b0;
    HEIGHT = '0; WIDTH = '0; ub_base_addr_i = '0;
    repeat (3) step();
    rst_i = 1'b0;
    step();

    // Basic drain
    launch(32, 64, 'h100);
    run_idle(500, 0);
    chk("basic_nreads", obs_reads, 64);
    chk("basic_done_lat", obs_done_edge - launch_edge, 64 + LAT);
    chk("basic_cfg_err", obs_errs, 0);
    step();

    // Stall three cycles after the fifth read
    launch(32, 32, 0);
    for (int i = 0; i < 50 && m_next < 5; i++) step();
    ub_stall_i = 1'b1;
    repeat (3) step();
    ub_stall_i = 1'b0;
    run_idle(500, 0);
    chk("stall_nreads", obs_reads, 32);
    chk("stall_done_lat", obs_done_edge - launch_edge, 32 + LAT + 3);

    // Zero rows
    launch(31, 64, 'h55);
    run_idle(20, 0);
    chk("zero_nreads", obs_reads, 0);
    chk("zero_done_lat", obs_done_edge - launch_edge, 1);
    step();

    // Base address wrap
    launch(32, 32, 'hFF0);
    run_idle(500, 0);
    chk("wrap_nreads", obs_reads, 32);

    // Clamp to accumulator depth
    launch(511, 511, 'h3);
    run_idle(3000, 0);
    chk("clamp_nreads", obs_reads, 1024);
    chk("clamp_cfg_err", obs_errs, 1);
    chk("clamp_dones", obs_dones, 1);

    // Reset mid-issue, with an ignored start while busy
    launch(64, 64, 'h20);
    for (int i = 0; i < 50 && m_next < 10; i++) begin
      if (i == 3) begin
        start_i = 1'b1;
        HEIGHT = 9'd32;
        WIDTH = 9'd32;
      end
      step();
    end
    chk("pre_reset_nreads", obs_reads, 10);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    repeat (8) step();
    chk("post_reset_dones", obs_dones, 0);
    launch(32, 32, 'h400);
    chk("restart_addr0", 32'(acc_rd_addr_o), 0);
    run_idle(500, 0);
    chk("restart_nreads", obs_reads, 32);

    // Randomised jobs with random stalls and stray starts
    for (int r = 0; r < 12; r++) begin
      ub_stall_i = ($urandom_range(0, 3) == 0);
      if (r % 2 == 0) launch($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 4095));
      else            launch($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 4095));
      run_idle(4000, 1);
      chk("rand_nreads", obs_reads, m_n);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
